// File: rtl/jk_counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// jk_counter_sequencer_pkg
//
// Shared definitions for the JK counter sequencer:
//   - state_t  : controller state encoding (IDLE, LOAD, SETTLE, COUNT, DONE, ERROR)
//   - DIR_UP / DIR_DOWN : encoding of the count direction input
// -----------------------------------------------------------------------------
package jk_counter_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_COUNT  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage : jk_counter_sequencer_pkg

// File: rtl/jk_toggle_gen.sv
// -----------------------------------------------------------------------------
// jk_toggle_gen
//
// Combinational toggle-enable generator for a ripple-free synchronous counter
// built from JK flip-flops. Bit 0 always toggles; bit i toggles when all lower
// bits are ones (count up) or all lower bits are zeros (count down).
//
// Ports:
//   Q    in   WIDTH  current bank contents
//   dir  in   1      DIR_UP / DIR_DOWN
//   t    out  WIDTH  per-bit toggle enable (drive J=K=t)
// -----------------------------------------------------------------------------
module jk_toggle_gen
   import jk_counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] Q,
   input  logic             dir,
   output logic [WIDTH-1:0] t
);

   assign t[0] = 1'b1;

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
         assign t[gi] = (dir == DIR_DOWN) ? (&(~Q[gi-1:0])) : (&Q[gi-1:0]);
      end
   endgenerate

endmodule : jk_toggle_gen

// File: rtl/jk_counter_sequencer.sv
// -----------------------------------------------------------------------------
// jk_counter_sequencer
//
// Turns a bank of WIDTH negedge-clocked JK flip-flops (async active-high
// Preset/Clear) into a loadable up/down counter. The bank is preloaded through
// Preset/Clear, stepped with per-bit J=K toggle enables, and stopped when the
// readback Q equals the terminal value. start/busy/done handshake with the
// requester.
//
// Optional feature macro: JK_SEQ_VERIFY_EN
//   defined   : readback is checked after the preload and after every step;
//               any mismatch enters ERROR and raises the sticky err flag.
//   undefined : no readback checks, ERROR unreachable, err tied low.
//
// Ports:
//   clk       in   1      controller clock (posedge); bank samples on negedge
//   Reset     in   1      synchronous active-high reset (bank is not touched)
//   start     in   1      run request, sampled in IDLE or ERROR only
//   dir       in   1      0 = up, 1 = down, latched at start
//   load_val  in   WIDTH  preload value, latched at start
//   term_val  in   WIDTH  terminal value, latched at start
//   pause     in   1      hold the count while high (COUNT only)
//   Q         in   WIDTH  bank readback
//   J, K      out  WIDTH  per-bit JK inputs to the bank
//   Preset    out  WIDTH  per-bit async set to the bank
//   Clear     out  WIDTH  per-bit async clear to the bank
//   busy      out  1      high in LOAD, SETTLE, COUNT
//   done      out  1      one-cycle pulse on reaching the terminal value
//   err       out  1      sticky readback error
// -----------------------------------------------------------------------------
module jk_counter_sequencer
   import jk_counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] term_val,
   input  logic             pause,
   input  logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Preset,
   output logic [WIDTH-1:0] Clear,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state_reg;
   logic             dir_reg;
   logic [WIDTH-1:0] term_reg;
   // Set for the single COUNT cycle after the terminal value was seen: the
   // drives are already released and done is raised on the following edge.
   logic             term_hit_reg;

   logic [WIDTH-1:0] toggle_vec;
   logic             term_match;
   logic             settle_fail;
   logic             count_fail;
   logic             count_step;

   jk_toggle_gen #(
      .WIDTH (WIDTH)
   ) u_toggle (
      .Q   (Q),
      .dir (dir_reg),
      .t   (toggle_vec)
   );

   assign term_match = (Q == term_reg);

   // A step is issued in COUNT only when nothing of higher priority applies:
   // pending done, readback error, terminal value, then pause.
   assign count_step = !term_hit_reg && !count_fail && !term_match && !pause;

`ifdef JK_SEQ_VERIFY_EN
   logic [WIDTH-1:0] load_reg;
   logic [WIDTH-1:0] prev_q_reg;
   logic [WIDTH-1:0] expect_q;
   logic             stepped_reg;
   logic             err_reg;

   // Value the bank must show one cycle after a step was driven.
   assign expect_q    = (dir_reg == DIR_DOWN) ? (prev_q_reg - WIDTH'(1))
                                              : (prev_q_reg + WIDTH'(1));
   assign settle_fail = (Q != load_reg);
   // Only cycles that follow a driven step are checked; after a paused cycle
   // the bank legitimately still holds the previous value.
   assign count_fail  = stepped_reg && (Q != expect_q);
   assign err         = err_reg;

   always_ff @(posedge clk) begin
      if (Reset) begin
         load_reg    <= '0;
         prev_q_reg  <= '0;
         stepped_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         if ((state_reg == ST_IDLE || state_reg == ST_ERROR) && start) begin
            load_reg <= load_val;
         end

         case (state_reg)
            ST_SETTLE: begin
               stepped_reg <= !settle_fail && !term_match;
               prev_q_reg  <= Q;
            end
            ST_COUNT: begin
               stepped_reg <= count_step;
               if (count_step) begin
                  prev_q_reg <= Q;
               end
            end
            default: begin
               stepped_reg <= 1'b0;
            end
         endcase

         if (state_reg == ST_SETTLE && settle_fail) begin
            err_reg <= 1'b1;
         end else if (state_reg == ST_COUNT && !term_hit_reg && count_fail) begin
            err_reg <= 1'b1;
         end else if (state_reg == ST_ERROR && start) begin
            err_reg <= 1'b0;
         end
      end
   end
`else
   assign settle_fail = 1'b0;
   assign count_fail  = 1'b0;
   assign err         = 1'b0;
`endif

   // Controller FSM. Every bank drive defaults to zero each cycle, so J/K,
   // Preset and Clear are only non-zero in the cycle a state asks for them.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_reg    <= ST_IDLE;
         dir_reg      <= DIR_UP;
         term_reg     <= '0;
         term_hit_reg <= 1'b0;
         J            <= '0;
         K            <= '0;
         Preset       <= '0;
         Clear        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         J      <= '0;
         K      <= '0;
         Preset <= '0;
         Clear  <= '0;
         done   <= 1'b0;

         case (state_reg)
            ST_IDLE, ST_ERROR: begin
               if (start) begin
                  dir_reg   <= dir;
                  term_reg  <= term_val;
                  // Each bit is either set or cleared, never both.
                  Preset    <= load_val;
                  Clear     <= ~load_val;
                  busy      <= 1'b1;
                  state_reg <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               state_reg <= ST_SETTLE;
            end

            ST_SETTLE: begin
               if (settle_fail) begin
                  busy      <= 1'b0;
                  state_reg <= ST_ERROR;
               end else if (term_match) begin
                  // Nothing to count: finish straight away.
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= ST_DONE;
               end else begin
                  // First step is issued on the same edge that enters COUNT.
                  J         <= toggle_vec;
                  K         <= toggle_vec;
                  state_reg <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (term_hit_reg) begin
                  term_hit_reg <= 1'b0;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  state_reg    <= ST_DONE;
               end else if (count_fail) begin
                  busy      <= 1'b0;
                  state_reg <= ST_ERROR;
               end else if (term_match) begin
                  // Terminal wins over pause; drives are already released.
                  term_hit_reg <= 1'b1;
               end else if (count_step) begin
                  J <= toggle_vec;
                  K <= toggle_vec;
               end
            end

            ST_DONE: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : jk_counter_sequencer
